reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback stage of the double-accumulator processor, directly upstream of the register file. It accepts completed results from execute over a valid/ready handshake and turns them into the register file's one-cycle write strobe (`write`, `Dest`, `wrData`). It also sequences the two-register writes needed by call-type instructions and waits, with a timeout, for load data from memory.

## Interface
- `DATA_W`, 16: datapath width; matches register file `wrData`.
- `MEM_TIMEOUT`, 15: maximum cycles spent in WAIT_MEM before aborting (1..255).
- `CLK` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: execute offers a result.
- `in_ready` out 1: stage can accept; asserted only in IDLE with `rst` high.
- `in_op` in 2: 0 NONE, 1 SINGLE, 2 DUAL, 3 LOAD.
- `in_dest` in 2: first destination (0 ACC, 1 ACCO, 2 SP, 3 RA).
- `in_data` in DATA_W: first write data (SINGLE/DUAL).
- `in_dest2` in 2: second destination (DUAL only).
- `in_data2` in DATA_W: second write data (DUAL only).
- `mem_valid` in 1: load data present; one-cycle pulse.
- `mem_rdata` in DATA_W: load data, qualified by `mem_valid`.
- `write` out 1: register file write enable; registered; one-cycle pulse per write.
- `Dest` out 2: register file destination; registered.
- `wrData` out DATA_W: register file write data; registered.
- `err` out 1: one-cycle pulse on load timeout.

## Operation
- Handshake: transfer occurs on a rising edge where `in_valid && in_ready`. `in_ready` is driven combinationally from state (IDLE).
- All operation fields are captured at the transfer edge. Later input changes have no effect on the operation in flight.
- NONE: consumed; no write; stays in IDLE.
- SINGLE: the next cycle presents `write=1`, `Dest=in_dest`, `wrData=in_data`; stays in IDLE.
- DUAL: the next cycle writes (`in_dest`, `in_data`), then goes to WR2. The cycle after that writes (`in_dest2`, `in_data2`), then returns to IDLE.
  - Equal destinations are legal; the second write wins.
- LOAD: goes to WAIT_MEM and clears the wait counter.
  - The first edge with `mem_valid=1` returns to IDLE. The next cycle writes (`in_dest`, `mem_rdata` sampled at that edge).
- Timeout: the counter increments each WAIT_MEM cycle without `mem_valid`. When it reaches `MEM_TIMEOUT`, the stage pulses `err` for one cycle, performs no write and returns to IDLE.
- `mem_valid` and the timeout at the same edge: data wins; the write happens and `err` stays 0.
- `mem_valid` outside WAIT_MEM is ignored.
- State machine: IDLE -> WR2 (DUAL), IDLE -> WAIT_MEM (LOAD), WR2 -> IDLE, WAIT_MEM -> IDLE (data or timeout).
- Reset (any time, including mid-DUAL or mid-LOAD) immediately sets:
  - state IDLE, counter 0;
  - `write=0`, `Dest=0`, `wrData=0`, `err=0`;
  - a pending second write or load is discarded.

## Timing
- Latency from transfer edge to `write` high: 1 cycle (SINGLE/DUAL first write).
- DUAL second write: 2 cycles after transfer.
- LOAD: 1 cycle after the `mem_valid` edge.
- Throughput:
  - SINGLE/NONE: 1 per cycle.
  - DUAL: 1 per 2 cycles.
  - LOAD: 1 + wait cycles.
- `write` is deasserted in every cycle not listed above. `Dest`/`wrData` hold their last values when `write=0`.
- Timeout: with no `mem_valid`, `err` is high in the cycle following the `MEM_TIMEOUT`-th WAIT_MEM edge.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `fwd_valid` (1), `fwd_dest` (2) and `fwd_data` (DATA_W).
  - These are combinational copies of `write`/`Dest`/`wrData`, for execute-stage forwarding of the value being written this cycle.
- Undefined: these ports are absent. Behaviour is otherwise identical.

## Structure
- Shared package `dap_pkg`:
  - destination codes `DEST_ACC=0`, `DEST_ACCO=1`, `DEST_SP=2`, `DEST_RA=3`;
  - op enum `wb_op_t` (NONE/SINGLE/DUAL/LOAD);
  - state enum `wb_state_t`.
- One sub-module, `wb_timeout_ctr`: clear/enable counter with a `hit` output at `MEM_TIMEOUT`.

## Test plan
- Reset held low 3 cycles, then released -> `write=0`, `Dest=0`, `wrData=0`, `err=0`, `in_ready=1`.
- SINGLE with dest=0, data=16'hD221 -> next cycle `write=1`, `Dest=0`, `wrData=16'hD221`. Back-to-back SINGLE to dest=1 with 16'h000F -> written in the following cycle with no bubble.
- DUAL with (3, 16'h0102) then (2, 16'hFFFE) -> two consecutive write cycles in that order; `in_ready=0` during the first.
- LOAD to dest=1, `mem_valid` after 4 cycles with 16'h00FF -> one write (1, 16'h00FF); `err=0`.
- LOAD with no `mem_valid` -> `err` pulse after 15 WAIT_MEM cycles and no write. A repeat with `mem_valid` exactly at the timeout edge -> write, no `err`.
- `rst` asserted in WR2 -> second write never appears; all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/dap_pkg.sv
// rtl/dap_pkg.sv - shared register codes and writeback enums for the double-accumulator processor
package dap_pkg;

    localparam logic [1:0] DEST_ACC  = 2'd0;
    localparam logic [1:0] DEST_ACCO = 2'd1;
    localparam logic [1:0] DEST_SP   = 2'd2;
    localparam logic [1:0] DEST_RA   = 2'd3;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_SINGLE = 2'd1,
        OP_DUAL   = 2'd2,
        OP_LOAD   = 2'd3
    } wb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR2      = 2'd1,
        ST_WAIT_MEM = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - clear/enable wait counter for the load timeout
module wb_timeout_ctr #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic CLK,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    // hit flags the edge on which this increment brings the count to MEM_TIMEOUT
    assign hit = en && (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - writeback stage driving the register file write strobe (option: WB_BYPASS_EN)
module reg_writeback
    import dap_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest2,
    input  logic [DATA_W-1:0] in_data2,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              write,
    output logic [1:0]        Dest,
    output logic [DATA_W-1:0] wrData,
    output logic              err
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd_valid,
    output logic [1:0]        fwd_dest,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    wb_state_t         state;
    logic [1:0]        hold_dest;
    logic [DATA_W-1:0] hold_data;
    logic              tmo_hit;

    assign in_ready = rst && (state == ST_IDLE);

    wb_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .CLK (CLK),
        .rst (rst),
        .clr (state != ST_WAIT_MEM),
        .en  ((state == ST_WAIT_MEM) && !mem_valid),
        .hit (tmo_hit)
    );

    // hold_dest/hold_data carry the second DUAL write, or the LOAD destination
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            hold_dest <= DEST_ACC;
            hold_data <= '0;
            write     <= 1'b0;
            Dest      <= DEST_ACC;
            wrData    <= '0;
            err       <= 1'b0;
        end else begin
            write <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (wb_op_t'(in_op))
                            OP_SINGLE: begin
                                write  <= 1'b1;
                                Dest   <= in_dest;
                                wrData <= in_data;
                            end
                            OP_DUAL: begin
                                write     <= 1'b1;
                                Dest      <= in_dest;
                                wrData    <= in_data;
                                hold_dest <= in_dest2;
                                hold_data <= in_data2;
                                state     <= ST_WR2;
                            end
                            OP_LOAD: begin
                                hold_dest <= in_dest;
                                state     <= ST_WAIT_MEM;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WR2: begin
                    write  <= 1'b1;
                    Dest   <= hold_dest;
                    wrData <= hold_data;
                    state  <= ST_IDLE;
                end
                ST_WAIT_MEM: begin
                    if (mem_valid) begin
                        write  <= 1'b1;
                        Dest   <= hold_dest;
                        wrData <= mem_rdata;
                        state  <= ST_IDLE;
                    end else if (tmo_hit) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_valid = write;
    assign fwd_dest  = Dest;
    assign fwd_data  = wrData;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - randomized and directed checks of reg_writeback against a behavioural model
module tb_reg_writeback;

    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'd0;
    logic [1:0]    in_dest = 2'd0;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_dest2 = 2'd0;
    logic [DW-1:0] in_data2 = '0;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          write;
    logic [1:0]    Dest;
    logic [DW-1:0] wrData;
    logic          err;
`ifdef WB_BYPASS_EN
    logic          fwd_valid;
    logic [1:0]    fwd_dest;
    logic [DW-1:0] fwd_data;
`endif

    reg_writeback #(.DATA_W(DW), .MEM_TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .in_dest2  (in_dest2),
        .in_data2  (in_data2),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .write     (write),
        .Dest      (Dest),
        .wrData    (wrData),
        .err       (err)
`ifdef WB_BYPASS_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: pending second write, outstanding load and its elapsed wait
    bit            m_write, m_err;
    logic [1:0]    m_dest;
    logic [DW-1:0] m_data;
    bit            dual_pend, ld_act;
    logic [1:0]    pend_dest, ld_dest;
    logic [DW-1:0] pend_data;
    int            ld_wait;

    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            m_write = 0; m_err = 0; m_dest = 0; m_data = 0;
            dual_pend = 0; ld_act = 0; ld_wait = 0;
        end else begin
            m_write = 0;
            m_err   = 0;
            if (dual_pend) begin
                m_write = 1; m_dest = pend_dest; m_data = pend_data;
                dual_pend = 0;
            end else if (ld_act) begin
                if (mem_valid) begin
                    m_write = 1; m_dest = ld_dest; m_data = mem_rdata;
                    ld_act = 0;
                end else begin
                    ld_wait = ld_wait + 1;
                    if (ld_wait == TMO) begin
                        m_err = 1;
                        ld_act = 0;
                    end
                end
            end else if (in_valid) begin
                if (in_op == 2'd1 || in_op == 2'd2) begin
                    m_write = 1; m_dest = in_dest; m_data = in_data;
                end
                if (in_op == 2'd2) begin
                    dual_pend = 1; pend_dest = in_dest2; pend_data = in_data2;
                end
                if (in_op == 2'd3) begin
                    ld_act = 1; ld_dest = in_dest; ld_wait = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            logic exp_rdy;
            exp_rdy = rst && !dual_pend && !ld_act;
            n_tot++;
            if (write === m_write && err === m_err && Dest === m_dest &&
                wrData === m_data && in_ready === exp_rdy
`ifdef WB_BYPASS_EN
                && fwd_valid === write && fwd_dest === Dest && fwd_data === wrData
`endif
               )
                n_pass++;
            else
                $display("FAIL model t=%0t: got w=%b d=%0d data=%h err=%b rdy=%b expected w=%b d=%0d data=%h err=%b rdy=%b",
                         $time, write, Dest, wrData, err, in_ready,
                         m_write, m_dest, m_data, m_err, exp_rdy);
        end
    end

    task automatic idle_in();
        in_valid = 0;
        mem_valid = 0;
    endtask

    task automatic offer(input logic [1:0] op, input logic [1:0] d, input logic [DW-1:0] v,
                         input logic [1:0] d2, input logic [DW-1:0] v2);
        in_valid = 1; in_op = op; in_dest = d; in_data = v; in_dest2 = d2; in_data2 = v2;
    endtask

    initial begin
        idle_in();
        repeat (3) @(negedge CLK);
        #1 rst = 1;
        chk_on = 1;

        @(negedge CLK);
        chk("rst_write", write, 0); chk("rst_dest", Dest, 0); chk("rst_data", wrData, 0);
        chk("rst_err", err, 0); chk("rst_ready", in_ready, 1);
        #1 offer(2'd1, 2'd0, 16'hD221, 2'd0, 16'h0);

        @(negedge CLK);
        chk("single1_w", write, 1); chk("single1_d", Dest, 0); chk("single1_v", wrData, 16'hD221);
        #1 offer(2'd1, 2'd1, 16'h000F, 2'd0, 16'h0);
        @(negedge CLK);
        chk("single2_w", write, 1); chk("single2_d", Dest, 1); chk("single2_v", wrData, 16'h000F);
        #1 idle_in();
        @(negedge CLK);
        chk("idle_w", write, 0); chk("hold_v", wrData, 16'h000F);
        #1 offer(2'd2, 2'd3, 16'h0102, 2'd2, 16'hFFFE);

        @(negedge CLK);
        chk("dual1_w", write, 1); chk("dual1_d", Dest, 3); chk("dual1_v", wrData, 16'h0102);
        chk("dual1_rdy", in_ready, 0);
        #1 idle_in();
        @(negedge CLK);
        chk("dual2_w", write, 1); chk("dual2_d", Dest, 2); chk("dual2_v", wrData, 16'hFFFE);
        @(negedge CLK);
        chk("dual_end_w", write, 0);
        #1 offer(2'd3, 2'd1, 16'h0, 2'd0, 16'h0);

        @(negedge CLK);
        #1 idle_in();
        repeat (3) begin
            @(negedge CLK);
            chk("load_wait_w", write, 0);
        end
        #1 begin mem_valid = 1; mem_rdata = 16'h00FF; end
        @(negedge CLK);
        chk("load_w", write, 1); chk("load_d", Dest, 1); chk("load_v", wrData, 16'h00FF);
        chk("load_err", err, 0);
        #1 begin mem_valid = 0; offer(2'd3, 2'd2, 16'h0, 2'd0, 16'h0); end

        @(negedge CLK);
        #1 idle_in();
        repeat (14) begin
            @(negedge CLK);
            chk("tmo_early_err", err, 0);
        end
        @(negedge CLK);
        chk("tmo_err", err, 1); chk("tmo_no_w", write, 0);
        @(negedge CLK);
        chk("tmo_err_pulse", err, 0);
        #1 offer(2'd3, 2'd3, 16'h0, 2'd0, 16'h0);

        @(negedge CLK);
        #1 idle_in();
        repeat (13) @(negedge CLK);
        @(negedge CLK);
        #1 begin mem_valid = 1; mem_rdata = 16'hABCD; end
        @(negedge CLK);
        chk("edge_w", write, 1); chk("edge_d", Dest, 3); chk("edge_v", wrData, 16'hABCD);
        chk("edge_err", err, 0);
        #1 mem_valid = 0;
        @(negedge CLK);
        chk("edge_err_after", err, 0);
        #1 offer(2'd2, 2'd1, 16'h1111, 2'd0, 16'h2222);

        @(negedge CLK);
        chk("wr2rst_first", write, 1);
        #1 begin idle_in(); rst = 0; end
        #1;
        chk("async_w", write, 0); chk("async_d", Dest, 0); chk("async_v", wrData, 0);
        chk("async_rdy", in_ready, 0);
        @(negedge CLK);
        #1 rst = 1;
        @(negedge CLK);
        chk("no_second_w", write, 0); chk("post_rst_rdy", in_ready, 1);

        repeat (3000) begin
            @(negedge CLK);
            #1;
            if (!rst) rst = 1;
            else if ($urandom_range(0, 399) == 0) rst = 0;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom);
            in_dest   = 2'($urandom);
            in_dest2  = 2'($urandom);
            in_data   = DW'($urandom);
            in_data2  = DW'($urandom);
            mem_valid = ($urandom_range(0, 19) == 0);
            mem_rdata = DW'($urandom);
        end
        @(negedge CLK);
        #1 begin idle_in(); rst = 1; end
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
